// File: rtl/idli_pkg.sv
// -----------------------------------------------------------------------------
// idli_pkg
// Shared definitions for the SQI responder: the two recognised command bytes
// and the responder state encoding.
// -----------------------------------------------------------------------------
package idli_pkg;

  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;
  localparam logic [7:0] SQI_CMD_READ  = 8'h03;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_IGNORE
  } resp_state_e;

endpackage

// File: rtl/idli_sqi_resp_m.sv
// -----------------------------------------------------------------------------
// idli_sqi_resp_m
// SQI (quad SPI) responder bridging a 4-bit serial link to a byte-wide
// backing store. A transaction is: 2 command nibbles, ADDR_W/4 address
// nibbles (MSB first), DUMMY_CYCLES dummy nibbles (reads only), then an
// unbounded stream of data nibbles, high nibble of each byte first.
//
// Ports
//   i_resp_gck          SQI clock; all logic on its rising edge
//   i_resp_rst          synchronous active-high reset (wins over everything)
//   i_resp_cs           1 = deselected / abort, 0 = selected
//   i_resp_wr_data      nibble from the initiator
//   o_resp_rd_data      nibble to the initiator (valid while o_resp_oe=1)
//   o_resp_oe           1 = responder drives SIO
//   o_resp_mem_addr     backing-store byte address (address register)
//   i_resp_mem_rd_data  byte at o_resp_mem_addr, combinational
//   o_resp_mem_wr_en    write strobe, taken by the store on this rising edge
//   o_resp_mem_wr_data  byte to write
// -----------------------------------------------------------------------------
module idli_sqi_resp_m
  import idli_pkg::*;
#(
  parameter int DUMMY_CYCLES = 2,
  parameter int ADDR_W       = 16
) (
  input  logic              i_resp_gck,
  input  logic              i_resp_rst,
  input  logic              i_resp_cs,
  input  logic [3:0]        i_resp_wr_data,
  output logic [3:0]        o_resp_rd_data,
  output logic              o_resp_oe,
  output logic [ADDR_W-1:0] o_resp_mem_addr,
  input  logic [7:0]        i_resp_mem_rd_data,
  output logic              o_resp_mem_wr_en,
  output logic [7:0]        o_resp_mem_wr_data
);

  localparam int ADDR_NIBS  = ADDR_W / 4;
  localparam int CNT_MAX    = (ADDR_NIBS > DUMMY_CYCLES) ?
                              ((ADDR_NIBS > 2) ? ADDR_NIBS : 2) :
                              ((DUMMY_CYCLES > 2) ? DUMMY_CYCLES : 2);
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int DUMMY_LAST = (DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0;

  resp_state_e       state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic              phase_q,  phase_d;   // 0 = high nibble, 1 = low nibble
  logic [3:0]        hi_nib_q, hi_nib_d;  // command high nibble / write high half
  logic              cmd_rd_q, cmd_rd_d;  // 1 = read transaction

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    phase_d  = phase_q;
    hi_nib_d = hi_nib_q;
    cmd_rd_d = cmd_rd_q;

    if (i_resp_cs) begin
      // Deselect aborts anything in flight, including a half-written byte.
      state_d = ST_CMD;
      cnt_d   = '0;
      phase_d = 1'b0;
    end else begin
      case (state_q)
        ST_CMD: begin
          if (cnt_q == '0) begin
            hi_nib_d = i_resp_wr_data;
            cnt_d    = CNT_W'(1);
          end else begin
            cnt_d   = '0;
            phase_d = 1'b0;
            case ({hi_nib_q, i_resp_wr_data})
              SQI_CMD_READ: begin
                cmd_rd_d = 1'b1;
                state_d  = ST_ADDR;
              end
              SQI_CMD_WRITE: begin
                cmd_rd_d = 1'b0;
                state_d  = ST_ADDR;
              end
              default: state_d = ST_IGNORE;
            endcase
          end
        end

        ST_ADDR: begin
          addr_d = {addr_q[ADDR_W-5:0], i_resp_wr_data};
          if (cnt_q == CNT_W'(ADDR_NIBS - 1)) begin
            cnt_d = '0;
            if (cmd_rd_q && (DUMMY_CYCLES > 0)) state_d = ST_DUMMY;
            else                                state_d = ST_DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_DUMMY: begin
          if (cnt_q == CNT_W'(DUMMY_LAST)) begin
            cnt_d   = '0;
            state_d = ST_DATA;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_DATA: begin
          // Same byte cadence for read and write: the address moves on once
          // both halves of the current byte have crossed the link.
          phase_d = ~phase_q;
          if (!phase_q) begin
            if (!cmd_rd_q) hi_nib_d = i_resp_wr_data;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end

        ST_IGNORE: ;

        default: state_d = ST_CMD;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge i_resp_gck) begin
    if (i_resp_rst) begin
      state_q  <= ST_CMD;
      cnt_q    <= '0;
      addr_q   <= '0;
      phase_q  <= 1'b0;
      hi_nib_q <= 4'h0;
      cmd_rd_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      phase_q  <= phase_d;
      hi_nib_q <= hi_nib_d;
      cmd_rd_q <= cmd_rd_d;
    end
  end

  assign o_resp_mem_addr    = addr_q;
  assign o_resp_oe          = (state_q == ST_DATA) && cmd_rd_q;
  assign o_resp_rd_data     = phase_q ? i_resp_mem_rd_data[3:0] : i_resp_mem_rd_data[7:4];
  // Strobe is masked by deselect and by reset so an abort can never commit.
  assign o_resp_mem_wr_en   = (state_q == ST_DATA) && !cmd_rd_q && phase_q &&
                              !i_resp_cs && !i_resp_rst;
  assign o_resp_mem_wr_data = {hi_nib_q, i_resp_wr_data};

endmodule

// File: tb/tb_idli_sqi_resp_m.sv
// -----------------------------------------------------------------------------
// tb_idli_sqi_resp_m
// Bench for idli_sqi_resp_m. Inputs change on the falling edge; outputs are
// compared 2 time units later against a transaction-position model (which
// nibble of the current selection this is), plus literal expectations for the
// documented scenarios. A simple byte store answers reads and takes writes.
// -----------------------------------------------------------------------------
module tb_idli_sqi_resp_m;
  import idli_pkg::*;

  localparam int ADDR_W = 16;
  localparam int DUMMY  = 2;
  localparam int NA     = ADDR_W / 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cs;
  logic [3:0]        wd;
  logic [3:0]        rd_data;
  logic              oe;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd;
  logic              we;
  logic [7:0]        wdat;

  always #5 clk = ~clk;

  idli_sqi_resp_m #(.DUMMY_CYCLES(DUMMY), .ADDR_W(ADDR_W)) dut (
    .i_resp_gck         (clk),
    .i_resp_rst         (rst),
    .i_resp_cs          (cs),
    .i_resp_wr_data     (wd),
    .o_resp_rd_data     (rd_data),
    .o_resp_oe          (oe),
    .o_resp_mem_addr    (mem_addr),
    .i_resp_mem_rd_data (mem_rd),
    .o_resp_mem_wr_en   (we),
    .o_resp_mem_wr_data (wdat)
  );

  // ---------------- backing store ----------------
  logic [7:0] mem [0:65535];
  logic       filled = 1'b0;

  function automatic logic [7:0] init_val(input int a);
    case (a)
      16'h0000: return 8'h5A;
      16'h0010: return 8'h7E;
      16'h0011: return 8'h81;
      16'hFFFF: return 8'hC3;
      default:  return 8'h00;
    endcase
  endfunction

  assign mem_rd = mem[mem_addr];

  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_val(i);
      filled <= 1'b1;
    end else if (we) begin
      mem[mem_addr] <= wdat;
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Position of the current nibble within the selection decides everything:
  // 0-1 command, then NA address nibbles, then dummies (reads), then data.
  int          m_idx  = 0;
  logic [7:0]  m_cmd  = 8'h00;
  logic [15:0] m_addr = 16'h0000;
  logic [3:0]  m_prev = 4'h0;

  function automatic int data_k(input int idx, input logic [7:0] cmd);
    int start;
    if (idx < 2 || !(cmd == SQI_CMD_READ || cmd == SQI_CMD_WRITE)) return -1;
    start = 2 + NA + ((cmd == SQI_CMD_READ) ? DUMMY : 0);
    return (idx >= start) ? idx - start : -1;
  endfunction

  always @(posedge clk) begin
    int k;
    k = data_k(m_idx, m_cmd);
    if (rst) begin
      m_idx  = 0;
      m_addr = 16'h0000;
    end else if (cs) begin
      m_idx = 0;
    end else begin
      if (m_idx == 1)
        m_cmd = {m_prev, wd};
      else if (m_idx >= 2 && m_idx < 2 + NA &&
               (m_cmd == SQI_CMD_READ || m_cmd == SQI_CMD_WRITE))
        m_addr = {m_addr[11:0], wd};
      if (k >= 0 && (k % 2) == 1) m_addr = m_addr + 16'h1;
      m_prev = wd;
      if (m_idx < 1000000) m_idx++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int   k;
    logic is_rd, exp_oe, exp_we;
    #2;
    if (chk_en) begin
      k      = data_k(m_idx, m_cmd);
      is_rd  = (m_cmd == SQI_CMD_READ);
      exp_oe = (k >= 0) && is_rd;
      exp_we = (k >= 0) && !is_rd && ((k % 2) == 1) && !cs && !rst;
      check("mem_addr", 32'(mem_addr), 32'(m_addr));
      check("oe", 32'(oe), 32'(exp_oe));
      check("wr_en", 32'(we), 32'(exp_we));
      if (exp_oe)
        check("rd_data", 32'(rd_data),
              32'(((k % 2) == 1) ? mem[m_addr][3:0] : mem[m_addr][7:4]));
      if (exp_we)
        check("wr_data", 32'(wdat), 32'({m_prev, wd}));
    end
  end

  // ---------------- observed traffic log ----------------
  logic [3:0] rdq[$];
  int         wr_cnt = 0;

  always @(negedge clk) begin
    #2;
    if (chk_en && oe && !cs) rdq.push_back(rd_data);
    if (chk_en && we) wr_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic c, input logic [3:0] d, input logic r);
    @(negedge clk);
    cs  = c;
    wd  = d;
    rst = r;
  endtask

  task automatic head(input logic [7:0] cmd, input logic [15:0] a);
    cyc(1'b0, cmd[7:4], 1'b0);
    cyc(1'b0, cmd[3:0], 1'b0);
    for (int i = NA - 1; i >= 0; i--) cyc(1'b0, a[i*4 +: 4], 1'b0);
  endtask

  task automatic dummies();
    for (int i = 0; i < DUMMY; i++) cyc(1'b0, 4'hF, 1'b0);
  endtask

  task automatic deselect(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 4'h0, 1'b0);
    #3;
  endtask

  task automatic read_stream(input logic [15:0] a, input int n);
    head(SQI_CMD_READ, a);
    dummies();
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 1'b0);
    deselect(2);
  endtask

  task automatic expect_nibs(input string name, input int base,
                             input logic [15:0] nibs, input int n);
    logic [15:0] v;
    v = nibs;
    check({name, "_count"}, 32'(rdq.size() - base), 32'(n));
    for (int i = 0; i < n; i++)
      if (base + i < rdq.size())
        check(name, 32'(rdq[base + i]), 32'(v[(n - 1 - i)*4 +: 4]));
  endtask

  initial begin
    int rb, wb;
    rst = 1'b1; cs = 1'b1; wd = 4'h0;
    cyc(1'b1, 4'h0, 1'b1);
    chk_en = 1'b1;
    cyc(1'b1, 4'h0, 1'b1);
    cyc(1'b1, 4'h0, 1'b0);
    #3;
    check("reset_addr", 32'(mem_addr), 32'h0);
    check("reset_oe", 32'(oe), 32'h0);
    check("reset_wr_en", 32'(we), 32'h0);

    // Two-byte write at 0x1234.
    wb = wr_cnt;
    head(SQI_CMD_WRITE, 16'h1234);
    cyc(1'b0, 4'hA, 1'b0); cyc(1'b0, 4'h5, 1'b0);
    cyc(1'b0, 4'h3, 1'b0); cyc(1'b0, 4'hC, 1'b0);
    deselect(2);
    check("wr_pulses", 32'(wr_cnt - wb), 32'd2);
    check("mem_1234", 32'(mem[16'h1234]), 32'hA5);
    check("mem_1235", 32'(mem[16'h1235]), 32'h3C);

    // Read 0x0010 through two dummies.
    rb = rdq.size();
    read_stream(16'h0010, 4);
    expect_nibs("rd_0010", rb, 16'h7E81, 4);

    // Read across the top of the address space.
    rb = rdq.size();
    read_stream(16'hFFFF, 4);
    expect_nibs("rd_wrap", rb, 16'hC35A, 4);

    // Abort after three write nibbles: only the first byte lands.
    wb = wr_cnt;
    head(SQI_CMD_WRITE, 16'h0200);
    cyc(1'b0, 4'h1, 1'b0); cyc(1'b0, 4'h2, 1'b0); cyc(1'b0, 4'h3, 1'b0);
    deselect(2);
    check("partial_pulses", 32'(wr_cnt - wb), 32'd1);
    check("mem_0200", 32'(mem[16'h0200]), 32'h12);
    check("mem_0201", 32'(mem[16'h0201]), 32'h00);
    rb = rdq.size();
    read_stream(16'h0200, 2);
    expect_nibs("rd_after_abort", rb, 16'h0012, 2);

    // Unknown command then ten nibbles: nothing happens.
    wb = wr_cnt;
    rb = rdq.size();
    cyc(1'b0, 4'h0, 1'b0); cyc(1'b0, 4'h5, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 4'(i + 3), 1'b0);
    #3;
    check("ignore_writes", 32'(wr_cnt - wb), 32'd0);
    check("ignore_oe", 32'(rdq.size() - rb), 32'd0);
    deselect(1);
    rb = rdq.size();
    read_stream(16'h1234, 2);
    expect_nibs("rd_after_ignore", rb, 16'h00A5, 2);

    // Reset in the middle of a read.
    head(SQI_CMD_READ, 16'h0010);
    dummies();
    cyc(1'b0, 4'h0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1);
    cyc(1'b1, 4'h0, 1'b0);
    #3;
    check("rst_mid_addr", 32'(mem_addr), 32'h0);
    check("rst_mid_oe", 32'(oe), 32'h0);
    deselect(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/idli_sqi_resp_m.md
IDLI_SQI_RESP_M -- requirements
Module: idli_sqi_resp_m

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: i_resp_gck is the SQI serial clock (SCK) as driven by the initiator; i_resp_rst resets on a rising i_resp_gck edge.
REQ-002 SHALL have parameters: DUMMY_CYCLES, default 2, clocked dummy nibbles before read data; ADDR_W, default 16, address width in bits (multiple of 4).
REQ-003 Ports (name direction width meaning):
- i_resp_gck in 1: SQI clock, all logic on rising edge.
- i_resp_rst in 1: sync active-high reset.
- i_resp_cs in 1: chip deselect; 1 = idle/abort, 0 = selected.
- i_resp_wr_data in 4: nibble from the initiator (SIO[3:0]).
- o_resp_rd_data out 4: nibble to the initiator.
- o_resp_oe out 1: 1 = responder drives SIO.
- o_resp_mem_addr out ADDR_W: backing-store byte address.
- i_resp_mem_rd_data in 8: byte at o_resp_mem_addr, combinational, same cycle.
- o_resp_mem_wr_en out 1: write strobe, sampled by the store on this rising edge.
- o_resp_mem_wr_data out 8: write byte.

Function
REQ-004 SHALL implement states CMD, ADDR, DUMMY, DATA, IGNORE, with a nibble counter sized for max(2, ADDR_W/4, DUMMY_CYCLES).
REQ-005 On any edge with i_resp_cs=1: state becomes CMD, counter becomes 0, and the byte-phase flag is cleared; no memory write occurs.
REQ-006 CMD: capture 2 nibbles, high nibble first; 0x03 = read, 0x02 = write, anything else goes to IGNORE; otherwise go to ADDR.
REQ-007 ADDR: shift ADDR_W/4 nibbles MSB-first into the address register; after the last nibble go to DUMMY for a read, DATA for a write.
REQ-008 DUMMY: ignore exactly DUMMY_CYCLES nibbles, then go to DATA; if DUMMY_CYCLES=0, go directly to DATA.
REQ-009 Read DATA: o_resp_rd_data = i_resp_mem_rd_data[7:4] in the first nibble cycle of each byte and [3:0] in the second; after the second nibble, the address increments.
REQ-010 o_resp_oe SHALL be 1 only while state=DATA and the command is read; it is 0 in every other case, including the cycle after i_resp_cs rises.
REQ-011 Write DATA: the first nibble of a byte is latched as the high half; on the second nibble cycle, o_resp_mem_wr_en=1 and o_resp_mem_wr_data={latched, i_resp_wr_data}; the address increments after that edge.
REQ-012 The address SHALL wrap from all-ones to 0 with no error indication; DATA continues indefinitely until i_resp_cs=1.
REQ-013 i_resp_cs rising after an odd number of write nibbles SHALL discard the partial byte.
REQ-014 IGNORE: all outputs inactive (oe=0, wr_en=0) until i_resp_cs=1.
REQ-015 o_resp_mem_addr SHALL always reflect the address register; o_resp_rd_data is don't-care when o_resp_oe=0.
REQ-016 o_resp_mem_wr_en is combinational from state, phase and cs, and SHALL never be 1 while i_resp_cs=1.

Reset
REQ-017 On i_resp_rst=1 at a rising edge: state=CMD, counter=0, address=0, phase=0, latched nibble=0, command=read; hence o_resp_oe=0 and o_resp_mem_wr_en=0.
REQ-018 i_resp_rst SHALL take priority over i_resp_cs and over all data activity.

Structure
REQ-019 The shared package idli_pkg SHALL hold the SQI command constants (0x02 write, 0x03 read) and the responder state enum; no other typedefs are added.
REQ-020 SHALL be a single module with no sub-module; the address register and counter live in-module.

Verification
REQ-021 Write 0x02, addr 0x1234, nibbles A,5,3,C -> wr_en pulses twice: (0x1234, 0xA5), then (0x1235, 0x3C).
REQ-022 Read 0x03, addr 0x0010, 2 dummies, mem[0x10]=0x7E, mem[0x11]=0x81 -> oe=0 through the dummies, then nibbles 7,E,8,1 with oe=1.
REQ-023 Read at addr 0xFFFF streaming 4 nibbles -> second byte fetched from address 0x0000.
REQ-024 Write with cs raised after 3 data nibbles -> exactly one write; no write for the third nibble; the next transaction decodes cleanly from CMD.
REQ-025 Command 0x05 followed by 10 nibbles -> no write, oe stays 0; a subsequent 0x03 read after a cs pulse works.
REQ-026 Assert i_resp_rst mid-read -> next edge: oe=0, address=0, state=CMD.
